// File: rtl/bcd_display_pkg.sv
// rtl/bcd_display_pkg.sv - shared types and segment codes for the BCD display driver
package bcd_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low a..g codes, entry 9 first so that SEG_TABLE[d] is digit d.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] seg_lookup(input logic [3:0] digit);
    if (digit > 4'd9) begin
      return SEG_BLANK;
    end
    return SEG_TABLE[digit];
  endfunction

endpackage

// File: rtl/bcd_display_driver_if.sv
// rtl/bcd_display_driver_if.sv - start/result bundle between a requester and the display driver
interface bcd_display_driver_if #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [DIGITS*7-1:0]   hex;

  modport master (
    output start, bin,
    input  busy, done, overflow, hex
  );

  modport slave (
    input  start, bin,
    output busy, done, overflow, hex
  );
endinterface

// File: rtl/seg7_encode.sv
// rtl/seg7_encode.sv - one BCD digit to active-low 7-segment code
module seg7_encode
  import bcd_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  assign seg_o = blank_i ? SEG_BLANK : seg_lookup(bcd_i);

endmodule

// File: rtl/bcd_display_driver.sv
// rtl/bcd_display_driver.sv - double-dabble binary to BCD conversion driving
// registered 7-segment outputs with leading-zero blanking and overflow dashes
module bcd_display_driver
  import bcd_display_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int DIGITS   = 4,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_display_driver_if.slave  bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_flag_q, ovf_flag_d;
  logic [7*DIGITS-1:0] hex_q, hex_d;
  logic                ovf_q, ovf_d;

  logic [BW-1:0]       bcd_adj, bcd_shift;
  logic                carry_out;
  logic                accept, last_shift;
  logic                lz_seen;
  logic [DIGITS-1:0]   blank;
  logic [7*DIGITS-1:0] seg;
  logic                busy, done;

  assign accept     = bus.start && (state_q != ST_SHIFT);
  assign last_shift = (state_q == ST_SHIFT) && (cnt_q == LAST_SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == LAST_SHIFT) state_d = ST_DONE;
      ST_DONE:  state_d = bus.start ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_SHIFT: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  // One double-dabble step: add-3 correction, then shift in the next bin MSB.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
    {carry_out, bcd_shift} = {bcd_adj, bin_q[WIDTH-1]};
  end

  always_comb begin
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_flag_d = ovf_flag_q;
    if (accept) begin
      bin_d      = bus.bin;
      bcd_d      = '0;
      cnt_d      = '0;
      ovf_flag_d = 1'b0;
    end else if (state_q == ST_SHIFT) begin
      bin_d      = bin_q << 1;
      bcd_d      = bcd_shift;
      cnt_d      = cnt_q + CW'(1);
      ovf_flag_d = ovf_flag_q | carry_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_flag_q <= 1'b0;
    end else begin
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_flag_q <= ovf_flag_d;
    end
  end

  // Display is built from the post-shift value so it lands with the DONE state.
  always_comb begin
    lz_seen = 1'b0;
    blank   = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (bcd_shift[4*k +: 4] != 4'd0) begin
        lz_seen = 1'b1;
      end
      blank[k] = BLANK_LZ && !lz_seen && (k != 0);
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    seg7_encode u_seg (
      .bcd_i   (bcd_shift[4*g +: 4]),
      .blank_i (blank[g]),
      .seg_o   (seg[7*g +: 7])
    );
  end

  assign ovf_d = ovf_flag_q | carry_out;
  assign hex_d = ovf_d ? {DIGITS{SEG_DASH}} : seg;

  always_ff @(posedge clk) begin
    if (rst) begin
      hex_q <= {DIGITS{SEG_BLANK}};
      ovf_q <= 1'b0;
    end else if (last_shift) begin
      hex_q <= hex_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.overflow = ovf_q;
  assign bus.hex      = hex_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// tb/tb_bcd_display_driver.sv - scoreboard bench for bcd_display_driver in three configurations
module tb_bcd_display_driver;

  typedef struct {
    logic [41:0] hex;
    logic        ovf;
    int          due;
  } exp_t;

  localparam logic [6:0] TB_SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                         7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  bin;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        q0[$], q1[$], q2[$];
  exp_t        e0, e1, e2;

  int          vbin [9] = '{1023, 7, 0, 1000, 999, 5, 305, 80, 1000};
  logic [27:0] vhex [9] = '{
    {7'h79, 7'h40, 7'h24, 7'h30},
    {7'h7F, 7'h7F, 7'h7F, 7'h78},
    {7'h7F, 7'h7F, 7'h7F, 7'h40},
    {7'h79, 7'h40, 7'h40, 7'h40},
    {7'h7F, 7'h10, 7'h10, 7'h10},
    {7'h7F, 7'h7F, 7'h7F, 7'h12},
    {7'h7F, 7'h30, 7'h40, 7'h12},
    {7'h7F, 7'h7F, 7'h00, 7'h40},
    {7'h79, 7'h40, 7'h40, 7'h40}
  };

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_display_driver_if #(.WIDTH(10), .DIGITS(4)) if0 ();
  bcd_display_driver_if #(.WIDTH(10), .DIGITS(4)) if1 ();
  bcd_display_driver_if #(.WIDTH(10), .DIGITS(3)) if2 ();

  assign if0.start = start;
  assign if0.bin   = bin;
  assign if1.start = start;
  assign if1.bin   = bin;
  assign if2.start = start;
  assign if2.bin   = bin;

  bcd_display_driver #(.WIDTH(10), .DIGITS(4), .BLANK_LZ(1'b1)) u0 (
    .clk(clk), .rst(rst), .bus(if0.slave));
  bcd_display_driver #(.WIDTH(10), .DIGITS(4), .BLANK_LZ(1'b0)) u1 (
    .clk(clk), .rst(rst), .bus(if1.slave));
  bcd_display_driver #(.WIDTH(10), .DIGITS(3), .BLANK_LZ(1'b1)) u2 (
    .clk(clk), .rst(rst), .bus(if2.slave));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic spurious(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=done expected=no_done (cycle %0d)", name, cyc);
  endtask

  // Decimal reference: digit extraction by division, independent of double-dabble.
  function automatic logic [41:0] model_hex(input int v, input int nd, input bit blz,
                                            output logic ovf);
    logic [41:0] r;
    int          digs [6];
    int          rem;
    int          top;
    r   = '0;
    rem = v;
    top = 0;
    for (int k = 0; k < nd; k++) begin
      digs[k] = rem % 10;
      rem     = rem / 10;
      if (digs[k] != 0) top = k;
    end
    ovf = (rem != 0);
    for (int k = 0; k < nd; k++) begin
      if (ovf)                 r[7*k +: 7] = 7'h3F;
      else if (blz && k > top) r[7*k +: 7] = 7'h7F;
      else                     r[7*k +: 7] = TB_SEG[digs[k]];
    end
    return r;
  endfunction

  task automatic push_exp(input int v, input logic [27:0] hex0, input int due);
    logic [41:0] h;
    logic        o;
    q0.push_back('{{14'b0, hex0}, 1'b0, due});
    h = model_hex(v, 4, 1'b0, o);
    q1.push_back('{h, o, due});
    h = model_hex(v, 3, 1'b1, o);
    q2.push_back('{h, o, due});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy0"}, if0.busy, 1'b0);
    check({tag, "_done0"}, if0.done, 1'b0);
    check({tag, "_hex0"},  if0.hex,  {4{7'h7F}});
    check({tag, "_hex1"},  if1.hex,  {4{7'h7F}});
    check({tag, "_hex2"},  if2.hex,  {3{7'h7F}});
    check({tag, "_ovf2"},  if2.overflow, 1'b0);
    check({tag, "_busy2"}, if2.busy, 1'b0);
  endtask

  task automatic conv(input int v, input logic [27:0] hex0);
    tick();
    start = 1'b1;
    bin   = 10'(v);
    push_exp(v, hex0, cyc + 11);
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("busy_mid", if0.busy, 1'b1);
    repeat (8) tick();
  endtask

  always @(negedge clk) begin
    if (if0.done) begin
      if (q0.size() == 0) spurious("dut0_unexpected_done");
      else begin
        e0 = q0.pop_front();
        check("dut0_hex", if0.hex, e0.hex);
        check("dut0_ovf", if0.overflow, e0.ovf);
        check("dut0_latency", cyc, e0.due);
      end
    end
  end

  always @(negedge clk) begin
    if (if1.done) begin
      if (q1.size() == 0) spurious("dut1_unexpected_done");
      else begin
        e1 = q1.pop_front();
        check("dut1_hex", if1.hex, e1.hex);
        check("dut1_ovf", if1.overflow, e1.ovf);
      end
    end
  end

  always @(negedge clk) begin
    if (if2.done) begin
      if (q2.size() == 0) spurious("dut2_unexpected_done");
      else begin
        e2 = q2.pop_front();
        check("dut2_hex", if2.hex, e2.hex);
        check("dut2_ovf", if2.overflow, e2.ovf);
      end
    end
  end

  initial begin
    int n;
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) tick();
    check_reset_state("reset");
    rst = 1'b0;
    tick();
    check_reset_state("post_reset");

    for (int i = 0; i < 9; i++) begin
      conv(vbin[i], vhex[i]);
    end

    // Second start during conversion must be ignored, not queued.
    tick();
    start = 1'b1;
    bin   = 10'd5;
    push_exp(5, {7'h7F, 7'h7F, 7'h7F, 7'h12}, cyc + 11);
    tick();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1;
    bin   = 10'd999;
    tick();
    start = 1'b0;
    repeat (20) tick();

    // Reset in the middle of a conversion aborts it with no done.
    tick();
    start = 1'b1;
    bin   = 10'd1023;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check_reset_state("abort");
    rst = 1'b0;
    repeat (15) tick();
    conv(0, {7'h7F, 7'h7F, 7'h7F, 7'h40});

    // Continuous start: back-to-back conversions, busy low only in DONE.
    tick();
    start = 1'b1;
    bin   = 10'd999;
    n     = cyc;
    for (int k = 1; k <= 3; k++) begin
      push_exp(999, {7'h7F, 7'h10, 7'h10, 7'h10}, n + 11 * k);
    end
    for (int off = 1; off <= 33; off++) begin
      tick();
      if (off == 23) start = 1'b0;
      check("b2b_busy", if0.busy, (off % 11) != 0);
    end
    repeat (5) tick();

    check("dut0_pending", q0.size(), 0);
    check("dut1_pending", q1.size(), 0);
    check("dut2_pending", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_display_driver.md
BCD_DISPLAY_DRIVER -- requirements
Module: bcd_display_driver

Interface
REQ-001 Parameter WIDTH, default 10: binary input width; legal range 4..20.
REQ-002 Parameter DIGITS, default 4: number of 7-segment digits driven; legal range 1..6.
REQ-003 Parameter BLANK_LZ, default 1: 1 = blank leading zeros, 0 = show all digits.
REQ-004 Port clk, input, 1 bit: single clock; every register updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 Port start, input, 1 bit: request to convert bin; sampled only while busy=0.
REQ-007 Port bin, input, WIDTH bits: unsigned binary value, captured on the accepted start cycle.
REQ-008 Port busy, output, 1 bit: high while a conversion is in progress.
REQ-009 Port done, output, 1 bit: one-cycle pulse when the display registers update.
REQ-010 Port overflow, output, 1 bit: high when the last conversion value is at least 10^DIGITS.
REQ-011 Port hex, output, DIGITS*7 bits: digit k occupies bits [7k+6:7k], with digit 0 as least significant; bit order within a digit is a..g (bit0=a, bit6=g); active-low.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-013 In IDLE or DONE, start=1 SHALL capture bin, clear the BCD accumulator and the overflow flag, and move to SHIFT.
REQ-014 SHIFT SHALL run exactly WIDTH cycles of double-dabble: first add 3 to every BCD nibble that is >=5, then shift left by 1, bringing in the next bin bit, MSB first.
REQ-015 A 1 shifted out of the top nibble during SHIFT SHALL set the sticky internal overflow flag.
REQ-016 After the WIDTH-th shift the FSM SHALL enter DONE for one cycle; in that cycle hex, overflow and done=1 SHALL all update together.
REQ-017 Latency: with start accepted at cycle 0, done SHALL be high at cycle WIDTH+1.
REQ-018 busy SHALL be 1 exactly while in SHIFT.
REQ-019 DONE SHALL return to IDLE unless start=1, in which case it goes directly to SHIFT.
REQ-020 start while busy=1 SHALL be ignored; it SHALL NOT be queued.
REQ-021 hex and overflow SHALL hold their last values from DONE until the next DONE.
REQ-022 On overflow, every digit SHALL show a dash, segment g only (7'h3F).
REQ-023 With BLANK_LZ=1, zero digits above the highest nonzero digit SHALL be blank (7'h7F); digit 0 SHALL always be shown, so value 0 displays "0".
REQ-024 Digit segment codes (hex) SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
REQ-025 A BCD nibble above 9 cannot occur; if one does, that digit SHALL be blank.

Reset
REQ-026 rst=1 SHALL force the FSM to IDLE, with busy=0, done=0 and overflow=0, and with every hex digit at 7'h7F.
REQ-027 rst SHALL take priority over start and SHALL abort an in-progress conversion with no done pulse.
REQ-028 After rst deasserts, the first start SHALL behave exactly as it does from a fresh IDLE.

Structure
REQ-029 Package bcd_display_pkg SHALL hold the state enum, SEG_BLANK=7'h7F, SEG_DASH=7'h3F and the digit code table.
REQ-030 Sub-module seg7_encode (4-bit BCD in, blank flag in, 7-bit active-low out) SHALL be instantiated once per digit.
REQ-031 The BCD accumulator SHALL be 4*DIGITS bits wide, and the shift counter SHALL be clog2(WIDTH+1) bits wide.

Verification (WIDTH=10, DIGITS=4 unless stated)
REQ-032 bin=1023, one-cycle start -> done at cycle 11; hex digits 3..0 = 79,40,24,30; overflow=0.
REQ-033 bin=7, BLANK_LZ=1 -> digits 3..1 = 7F and digit 0 = 78; rerun with BLANK_LZ=0 -> 40,40,40,78.
REQ-034 DIGITS=3, bin=1000 -> overflow=1 and all three digits = 3F; then bin=999 -> overflow=0 with digits 10,10,10.
REQ-035 start pulsed again at cycle 4 of a conversion of bin=5 -> exactly one done pulse, and the displayed value is 5.
REQ-036 rst asserted at cycle 6 of a conversion -> no done pulse, busy=0 and hex all 7F on the next cycle; a fresh start with bin=0 -> digit 0 = 40 and the others 7F.
REQ-037 start held high continuously -> back-to-back conversions, with done every 11 cycles and busy low only in the DONE cycles.
